floo_rsp_packer: RTL and testbench
==================================

// Module: floo_rsp_packer
// PURPOSE
// - Consumes B/R responses plus buffered return-route meta from the meta buffer; emits one response flit stream to NoC.
// - Arbitrates B vs R per flit, round-robin, into a single registered output stage.
// - Sits in the chimney response path, directly downstream of the meta buffer's r_buf_o/b_buf_o.
// PARAMETERS
// - IdWidth      4   AXI ID width carried back in payload
// - DataWidth    64  R data width
// - DstIdWidth   6   NoC destination (return route) width
// - PayloadWidth = DataWidth+IdWidth+2 (localparam, derived)
// PORTS
// - clk_i           in   1           clock
// - rst_i           in   1           synchronous reset, active-high
// - b_valid_i       in   1           B response valid
// - b_ready_o       out  1           B response accepted
// - b_id_i          in   IdWidth     restored AXI ID
// - b_resp_i        in   2           AXI resp
// - b_dst_i         in   DstIdWidth  return destination from b meta
// - r_valid_i       in   1           R beat valid
// - r_ready_o       out  1           R beat accepted
// - r_id_i          in   IdWidth     restored AXI ID
// - r_data_i        in   DataWidth   read data
// - r_resp_i        in   2           AXI resp
// - r_last_i        in   1           last beat of burst
// - r_dst_i         in   DstIdWidth  return destination from r meta
// - flit_valid_o    out  1           flit valid
// - flit_ready_i    in   1           NoC accepts flit
// - flit_dst_o      out  DstIdWidth  flit destination
// - flit_ch_o       out  2           channel: CH_B=2'd1, CH_R=2'd2
// - flit_last_o     out  1           r_last for R; 1 for B
// - flit_payload_o  out  PayloadWidth R: {data,id,resp}; B: {'0,id,resp} right-aligned
// BEHAVIOUR
// - Reset: flit_valid_o=0, all flit_* fields 0, prio_q=R, lock_q=0; in-flight flit discarded (upstream reset jointly).
// - Output register: load = !flit_valid_o || flit_ready_i; latency exactly 1 cycle; full throughput.
// - Grant: if only one input valid, grant it; both valid -> grant per prio_q. No grant when !load.
// - b_ready_o = load && grant_b; r_ready_o = load && grant_r; ready may depend on flit_ready_i combinationally.
// - Input valid/payload must be held until ready (AXI rule); block never drops or duplicates a beat.
// - Flit held stable while flit_valid_o && !flit_ready_i.
// - prio_q updated only on an accepted grant: prio_q <= other channel than granted.
// - Simultaneous flit_ready_i and new grant: old flit retires, new flit loaded same edge, valid stays 1.
// - No input valid and flit accepted: flit_valid_o drops to 0 next cycle.
// CONFIGURATION
// - FLOO_RSP_PACKER_R_BURST_LOCK_EN defined: lock_q set on accepted R beat with r_last_i=0,
//   cleared on accepted R beat with r_last_i=1; while lock_q, B is never granted (R bursts contiguous).
// - Not defined: no lock_q; pure per-beat round-robin, B may interleave inside R bursts.
// STRUCTURE
// - floo_pkg: ch_e enum (CH_NONE=0, CH_B=1, CH_R=2), payload packing functions.
// - Sub-module floo_rsp_arb: 2-input round-robin arbiter with prio_q and optional lock.
// - Top: arbiter + mux + output register.
// TESTING
// - Reset then idle: flit_valid_o=0, ready outputs follow load=1, no flit emitted for 10 cycles.
// - Single B (id=3,resp=0,dst=5), flit_ready_i=1 -> flit next cycle: ch=1,last=1,payload[5:0]=6'h0C,dst=5.
// - B and R(id=2,last=1) valid same cycle after reset -> R flit first, B flit next cycle; prio_q back to R.
// - 4-beat R burst + B valid at beat 1: lock off -> B emitted after beat 1; lock on -> B after beat 4.
// - flit_ready_i=0 for 5 cycles with R pending -> flit stable, r_ready_o=0; release -> 1 flit/cycle resumes.
// - rst_i asserted mid-burst -> next cycle flit_valid_o=0, lock_q=0, prio_q=R.

Source files
------------

// File: rtl/floo_pkg.sv
// floo_pkg: shared types and payload packing helpers for the FlooNoC response path.
// Packing helpers work on a wide container so any configured width fits; callers truncate.
package floo_pkg;

    typedef enum logic [1:0] {
        CH_NONE = 2'd0,
        CH_B    = 2'd1,
        CH_R    = 2'd2
    } ch_e;

    localparam int unsigned MaxPayloadWidth = 256;

    typedef logic [MaxPayloadWidth-1:0] payload_t;

    function automatic payload_t pack_b(input payload_t id, input logic [1:0] resp);
        return (id << 2) | payload_t'(resp);
    endfunction

    function automatic payload_t pack_r(input payload_t data, input payload_t id,
                                        input logic [1:0] resp, input int unsigned idWidth);
        return (data << (idWidth + 2)) | (id << 2) | payload_t'(resp);
    endfunction

endpackage

// File: rtl/floo_rsp_arb.sv
// floo_rsp_arb: two-input (B/R) round-robin grant with a registered priority pointer.
// FLOO_RSP_PACKER_R_BURST_LOCK_EN keeps R bursts contiguous by blocking B mid-burst.
module floo_rsp_arb
    import floo_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic b_valid_i,
    input  logic r_valid_i,
    input  logic r_last_i,
    output logic grant_b_o,
    output logic grant_r_o
);

    ch_e  r_prio;
    ch_e  w_prioNext;
    logic w_lock;

`ifdef FLOO_RSP_PACKER_R_BURST_LOCK_EN
    logic r_lock;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lock <= 1'b0;
        end else if (grant_r_o) begin
            r_lock <= !r_last_i;
        end
    end

    assign w_lock = r_lock;
`else
    logic w_unusedLast;

    assign w_unusedLast = r_last_i;
    assign w_lock       = 1'b0;
`endif

    always_comb begin
        grant_b_o  = 1'b0;
        grant_r_o  = 1'b0;
        w_prioNext = r_prio;
        if (load_i) begin
            if (w_lock) begin
                grant_r_o = r_valid_i;
            end else if (b_valid_i && r_valid_i) begin
                grant_r_o = (r_prio == CH_R);
                grant_b_o = (r_prio != CH_R);
            end else begin
                grant_b_o = b_valid_i;
                grant_r_o = r_valid_i;
            end
        end
        // The channel just served drops to lowest priority.
        if (grant_b_o) begin
            w_prioNext = CH_R;
        end else if (grant_r_o) begin
            w_prioNext = CH_B;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_prio <= CH_R;
        end else begin
            r_prio <= w_prioNext;
        end
    end

endmodule

// File: rtl/floo_rsp_packer.sv
// floo_rsp_packer: merges B and R responses into one registered response flit stream.
// Define FLOO_RSP_PACKER_R_BURST_LOCK_EN to keep R bursts uninterrupted by B flits.
module floo_rsp_packer
    import floo_pkg::*;
#(
    parameter int unsigned IdWidth    = 4,
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned DstIdWidth = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  b_valid_i,
    output logic                  b_ready_o,
    input  logic [IdWidth-1:0]    b_id_i,
    input  logic [1:0]            b_resp_i,
    input  logic [DstIdWidth-1:0] b_dst_i,
    input  logic                  r_valid_i,
    output logic                  r_ready_o,
    input  logic [IdWidth-1:0]    r_id_i,
    input  logic [DataWidth-1:0]  r_data_i,
    input  logic [1:0]            r_resp_i,
    input  logic                  r_last_i,
    input  logic [DstIdWidth-1:0] r_dst_i,
    output logic                  flit_valid_o,
    input  logic                  flit_ready_i,
    output logic [DstIdWidth-1:0] flit_dst_o,
    output logic [1:0]            flit_ch_o,
    output logic                  flit_last_o,
    output logic [DataWidth+IdWidth+1:0] flit_payload_o
);

    localparam int unsigned PayloadWidth = DataWidth + IdWidth + 2;

    logic                    w_load;
    logic                    w_grantB;
    logic                    w_grantR;
    logic [PayloadWidth-1:0] w_payloadB;
    logic [PayloadWidth-1:0] w_payloadR;

    logic                    r_flitValid;
    logic [DstIdWidth-1:0]   r_flitDst;
    ch_e                     r_flitCh;
    logic                    r_flitLast;
    logic [PayloadWidth-1:0] r_flitPayload;

    assign w_load = !r_flitValid || flit_ready_i;

    floo_rsp_arb u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (w_load),
        .b_valid_i (b_valid_i),
        .r_valid_i (r_valid_i),
        .r_last_i  (r_last_i),
        .grant_b_o (w_grantB),
        .grant_r_o (w_grantR)
    );

    assign b_ready_o = w_grantB;
    assign r_ready_o = w_grantR;

    assign w_payloadB = PayloadWidth'(pack_b(payload_t'(b_id_i), b_resp_i));
    assign w_payloadR = PayloadWidth'(pack_r(payload_t'(r_data_i), payload_t'(r_id_i),
                                             r_resp_i, IdWidth));

    // A retiring flit and a new grant share the same edge, so valid stays high back to back.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_flitValid   <= 1'b0;
            r_flitDst     <= '0;
            r_flitCh      <= CH_NONE;
            r_flitLast    <= 1'b0;
            r_flitPayload <= '0;
        end else if (w_load) begin
            r_flitValid <= w_grantB || w_grantR;
            if (w_grantB) begin
                r_flitDst     <= b_dst_i;
                r_flitCh      <= CH_B;
                r_flitLast    <= 1'b1;
                r_flitPayload <= w_payloadB;
            end else if (w_grantR) begin
                r_flitDst     <= r_dst_i;
                r_flitCh      <= CH_R;
                r_flitLast    <= r_last_i;
                r_flitPayload <= w_payloadR;
            end
        end
    end

    assign flit_valid_o   = r_flitValid;
    assign flit_dst_o     = r_flitDst;
    assign flit_ch_o      = r_flitCh;
    assign flit_last_o    = r_flitLast;
    assign flit_payload_o = r_flitPayload;

endmodule

// File: tb/tb_floo_rsp_packer.sv
// tb_floo_rsp_packer: directed scenarios plus randomized B/R traffic against a
// cycle-level reference model; honours FLOO_RSP_PACKER_R_BURST_LOCK_EN like the design.
module tb_floo_rsp_packer;

    typedef logic [127:0] cmp_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;

    logic        inBValid = 1'b0;
    logic [3:0]  inBId = '0;
    logic [1:0]  inBResp = '0;
    logic [5:0]  inBDst = '0;
    logic        inRValid = 1'b0;
    logic [3:0]  inRId = '0;
    logic [63:0] inRData = '0;
    logic [1:0]  inRResp = '0;
    logic        inRLast = 1'b0;
    logic [5:0]  inRDst = '0;
    logic        inFlitReady = 1'b0;

    logic        b_ready_o;
    logic        r_ready_o;
    logic        flit_valid_o;
    logic [5:0]  flit_dst_o;
    logic [1:0]  flit_ch_o;
    logic        flit_last_o;
    logic [69:0] flit_payload_o;

    // Source-side requests; the model clears a valid once its beat is accepted.
    logic        srcBValid = 1'b0;
    logic [3:0]  srcBId = '0;
    logic [1:0]  srcBResp = '0;
    logic [5:0]  srcBDst = '0;
    logic        srcRValid = 1'b0;
    logic [3:0]  srcRId = '0;
    logic [63:0] srcRData = '0;
    logic [1:0]  srcRResp = '0;
    logic        srcRLast = 1'b0;
    logic [5:0]  srcRDst = '0;
    logic        srcFlitReady = 1'b0;
    int          rRemain = 0;
    logic [3:0]  rBurstId = '0;
    logic [5:0]  rBurstDst = '0;

    // Reference model: the flit the NoC should currently see, plus who goes first on a tie.
    logic        mValid = 1'b0;
    logic [5:0]  mDst = '0;
    logic [1:0]  mCh = '0;
    logic        mLast = 1'b0;
    logic [69:0] mPayload = '0;
    logic        mPreferR = 1'b1;
    logic        mInBurst = 1'b0;

    logic [1:0]  obsCh [$];
    int          compareCount = 0;
    int          mismatchCount = 0;

    floo_rsp_packer #(
        .IdWidth    (4),
        .DataWidth  (64),
        .DstIdWidth (6)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .b_valid_i      (inBValid),
        .b_ready_o      (b_ready_o),
        .b_id_i         (inBId),
        .b_resp_i       (inBResp),
        .b_dst_i        (inBDst),
        .r_valid_i      (inRValid),
        .r_ready_o      (r_ready_o),
        .r_id_i         (inRId),
        .r_data_i       (inRData),
        .r_resp_i       (inRResp),
        .r_last_i       (inRLast),
        .r_dst_i        (inRDst),
        .flit_valid_o   (flit_valid_o),
        .flit_ready_i   (inFlitReady),
        .flit_dst_o     (flit_dst_o),
        .flit_ch_o      (flit_ch_o),
        .flit_last_o    (flit_last_o),
        .flit_payload_o (flit_payload_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input cmp_t observed, input cmp_t expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock of traffic: check the held flit, drive sources, check readies, advance the model.
    task automatic applyStimulus();
        logic load;
        logic gB;
        logic gR;
        @(negedge clk_i);
        checkOutput("flitValid", cmp_t'(flit_valid_o), cmp_t'(mValid));
        if (mValid) begin
            checkOutput("flitDst", cmp_t'(flit_dst_o), cmp_t'(mDst));
            checkOutput("flitCh", cmp_t'(flit_ch_o), cmp_t'(mCh));
            checkOutput("flitLast", cmp_t'(flit_last_o), cmp_t'(mLast));
            checkOutput("flitPayload", cmp_t'(flit_payload_o), cmp_t'(mPayload));
        end
        inBValid = srcBValid;  inBId = srcBId;  inBResp = srcBResp;  inBDst = srcBDst;
        inRValid = srcRValid;  inRId = srcRId;  inRData = srcRData;  inRResp = srcRResp;
        inRLast = srcRLast;    inRDst = srcRDst; inFlitReady = srcFlitReady;
        #1;
        if (flit_valid_o && inFlitReady) obsCh.push_back(flit_ch_o);
        load = !mValid || inFlitReady;
        gB = 1'b0;
        gR = 1'b0;
        if (load) begin
            if (mInBurst) gR = inRValid;
            else if (inBValid && inRValid) begin
                gR = mPreferR;
                gB = !mPreferR;
            end else begin
                gB = inBValid;
                gR = inRValid;
            end
        end
        checkOutput("bReady", cmp_t'(b_ready_o), cmp_t'(gB));
        checkOutput("rReady", cmp_t'(r_ready_o), cmp_t'(gR));
        if (gB) begin
            mValid = 1'b1; mDst = inBDst; mCh = 2'd1; mLast = 1'b1;
            mPayload = (70'(inBId) << 2) | 70'(inBResp);
            mPreferR = 1'b1;
            srcBValid = 1'b0;
        end else if (gR) begin
            mValid = 1'b1; mDst = inRDst; mCh = 2'd2; mLast = inRLast;
            mPayload = (70'(inRData) << 6) | (70'(inRId) << 2) | 70'(inRResp);
            mPreferR = 1'b0;
`ifdef FLOO_RSP_PACKER_R_BURST_LOCK_EN
            mInBurst = !inRLast;
`endif
            srcRValid = 1'b0;
        end else if (load) begin
            mValid = 1'b0;
        end
    endtask

    task automatic resetDut();
        @(negedge clk_i);
        rst_i = 1'b1;
        srcBValid = 1'b0; srcRValid = 1'b0; rRemain = 0;
        inBValid = 1'b0;  inRValid = 1'b0;
        @(posedge clk_i);
        #1;
        checkOutput("rstValid", cmp_t'(flit_valid_o), cmp_t'(0));
        checkOutput("rstDst", cmp_t'(flit_dst_o), cmp_t'(0));
        checkOutput("rstCh", cmp_t'(flit_ch_o), cmp_t'(0));
        checkOutput("rstLast", cmp_t'(flit_last_o), cmp_t'(0));
        checkOutput("rstPayload", cmp_t'(flit_payload_o), cmp_t'(0));
        @(negedge clk_i);
        rst_i = 1'b0;
        mValid = 1'b0; mDst = '0; mCh = '0; mLast = 1'b0; mPayload = '0;
        mPreferR = 1'b1; mInBurst = 1'b0;
        obsCh.delete();
    endtask

    task automatic loadB(input logic [3:0] id, input logic [1:0] resp, input logic [5:0] dst);
        srcBValid = 1'b1; srcBId = id; srcBResp = resp; srcBDst = dst;
    endtask

    task automatic loadR(input logic [3:0] id, input logic last, input logic [5:0] dst);
        srcRValid = 1'b1; srcRId = id; srcRData = {$urandom, $urandom};
        srcRResp = 2'($urandom); srcRLast = last; srcRDst = dst;
    endtask

    function automatic cmp_t obsAt(input int idx);
        return (idx < obsCh.size()) ? cmp_t'(obsCh[idx]) : cmp_t'(3);
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0] expSeq [5];
        int beats;

        // Idle after reset: nothing emitted for 10 cycles.
        resetDut();
        srcFlitReady = 1'b1;
        for (int i = 0; i < 10; i++) applyStimulus();
        checkOutput("idleFlits", cmp_t'(obsCh.size()), cmp_t'(0));

        // Single B flit and its packed payload.
        loadB(4'd3, 2'd0, 6'd5);
        applyStimulus();
        applyStimulus();
        checkOutput("bCh", cmp_t'(flit_ch_o), cmp_t'(1));
        checkOutput("bLast", cmp_t'(flit_last_o), cmp_t'(1));
        checkOutput("bPayloadLow", cmp_t'(flit_payload_o[5:0]), cmp_t'(6'h0C));
        checkOutput("bDst", cmp_t'(flit_dst_o), cmp_t'(5));
        applyStimulus();

        // B and R together: R wins after reset, then priority returns to R.
        resetDut();
        srcFlitReady = 1'b1;
        for (int round = 0; round < 2; round++) begin
            loadB(4'd1, 2'd0, 6'd1);
            loadR(4'd2, 1'b1, 6'd3);
            for (int i = 0; i < 3; i++) applyStimulus();
        end
        checkOutput("tieCount", cmp_t'(obsCh.size()), cmp_t'(4));
        checkOutput("tie0", obsAt(0), cmp_t'(2));
        checkOutput("tie1", obsAt(1), cmp_t'(1));
        checkOutput("tie2", obsAt(2), cmp_t'(2));
        checkOutput("tie3", obsAt(3), cmp_t'(1));

        // Four-beat R burst with B arriving alongside the first beat.
        resetDut();
        srcFlitReady = 1'b1;
        beats = 0;
        loadB(4'd7, 2'd1, 6'd9);
`ifdef FLOO_RSP_PACKER_R_BURST_LOCK_EN
        expSeq = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
`else
        expSeq = '{2'd2, 2'd1, 2'd2, 2'd2, 2'd2};
`endif
        for (int i = 0; i < 10; i++) begin
            if (!srcRValid && beats < 4) begin
                loadR(4'd5, beats == 3, 6'd2);
                beats++;
            end
            applyStimulus();
        end
        checkOutput("burstCount", cmp_t'(obsCh.size()), cmp_t'(5));
        for (int i = 0; i < 5; i++) checkOutput("burstOrder", obsAt(i), cmp_t'(expSeq[i]));

        // Backpressure: flit held, R not accepted; release gives one flit per cycle.
        resetDut();
        srcFlitReady = 1'b0;
        loadR(4'd4, 1'b1, 6'd6);
        applyStimulus();
        loadR(4'd4, 1'b1, 6'd7);
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkOutput("stallRReady", cmp_t'(r_ready_o), cmp_t'(0));
        end
        srcFlitReady = 1'b1;
        applyStimulus();
        loadR(4'd4, 1'b1, 6'd8);
        applyStimulus();
        applyStimulus();
        checkOutput("releaseFlits", cmp_t'(obsCh.size()), cmp_t'(3));
        applyStimulus();

        // Reset in the middle of a burst clears the output, lock and priority.
        resetDut();
        srcFlitReady = 1'b1;
        loadR(4'd9, 1'b0, 6'd10);
        applyStimulus();
        loadR(4'd9, 1'b0, 6'd10);
        applyStimulus();
        resetDut();
        srcFlitReady = 1'b1;
        loadB(4'd2, 2'd3, 6'd11);
        applyStimulus();
        checkOutput("postRstBReady", cmp_t'(b_ready_o), cmp_t'(1));
        applyStimulus();
        obsCh.delete();
        loadB(4'd6, 2'd2, 6'd12);
        loadR(4'd8, 1'b1, 6'd13);
        for (int i = 0; i < 3; i++) applyStimulus();
        checkOutput("postRstFirst", obsAt(0), cmp_t'(2));

        // Randomized traffic with bursts and sink backpressure.
        resetDut();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!srcBValid && $urandom_range(0, 2) == 0)
                loadB(4'($urandom), 2'($urandom), 6'($urandom));
            if (!srcRValid && $urandom_range(0, 1) == 0) begin
                if (rRemain == 0) begin
                    rRemain   = $urandom_range(1, 4);
                    rBurstId  = 4'($urandom);
                    rBurstDst = 6'($urandom);
                end
                loadR(rBurstId, rRemain == 1, rBurstDst);
                rRemain--;
            end
            srcFlitReady = ($urandom_range(0, 3) != 0);
            applyStimulus();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
